io_input_responder: RTL and testbench

- User-side responder for the CPU input instruction (inop).
- When the CPU raises inop, the block holds await high to stall the CPU clock gate.
- It waits for a fresh, debounced button press, then latches the 14-bit switch word, extends it to 32 bits onto du, and releases await with a one-cycle done pulse.
- It runs on the divided system clock, alongside the output/display path.

---
 rtl/io_input_responder.sv | 128 ++++++++++++
 tb/tb_io_input_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/io_input_responder.sv
// Responder for the CPU input instruction: stalls the CPU until a debounced
// button press captures the switch word onto du.
module io_input_responder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit SIGN_EXT        = 1'b0
) (
    input  logic        clk,
    input  logic        bt_reset,
    input  logic        inop,
    input  logic        bt,
    input  logic [13:0] in,
    output logic [31:0] du,
    output logic        await,
    output logic        done,
    output logic [7:0]  count
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        DEBOUNCE,
        ACK,
        WAIT_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   du_q, du_d;
    logic          done_q, done_d;
    logic [7:0]    count_q, count_d;

    logic          bt_meta_q, bt_s_q;
    logic [13:0]   in_meta_q, in_s_q;
    logic [31:0]   in_ext;

    always_comb begin
        if (SIGN_EXT) in_ext = {{18{in_s_q[13]}}, in_s_q};
        else          in_ext = {18'b0, in_s_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        du_d    = du_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (inop) state_d = bt_s_q ? WAIT_RELEASE : WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!inop) begin
                    state_d = IDLE;
                end else if (bt_s_q) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (!inop) begin
                    state_d = IDLE;
                end else if (!bt_s_q) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ACK;
                    du_d    = in_ext;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
            WAIT_RELEASE: begin
                if (bt_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = inop ? WAIT_PRESS : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        done_d = (state_d == ACK);
    end

    always_ff @(posedge clk or negedge bt_reset) begin
        if (!bt_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            du_q      <= '0;
            done_q    <= 1'b0;
            count_q   <= '0;
            bt_meta_q <= 1'b0;
            bt_s_q    <= 1'b0;
            in_meta_q <= '0;
            in_s_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            du_q      <= du_d;
            done_q    <= done_d;
            count_q   <= count_d;
            bt_meta_q <= bt;
            bt_s_q    <= bt_meta_q;
            in_meta_q <= in;
            in_s_q    <= in_meta_q;
        end
    end

    // Stall drops combinationally in ACK so the CPU resumes with du valid.
    assign await = inop & (state_q != ACK);
    assign du    = du_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_io_input_responder.sv
// Directed bench for io_input_responder; zero- and sign-extending
// instances share the same stimulus.
module tb_io_input_responder;

    logic        clk = 1'b0;
    logic        bt_reset = 1'b0;
    logic        inop = 1'b0;
    logic        bt = 1'b0;
    logic [13:0] sw = '0;

    logic [31:0] du0, du1;
    logic        aw0, aw1, dn0, dn1;
    logic [7:0]  cnt0, cnt1;

    int tests = 0;
    int fails = 0;
    int ndone = 0;
    int n0;
    logic [31:0] dv;

    io_input_responder #(.DEBOUNCE_CYCLES(4), .SIGN_EXT(1'b0)) u0 (
        .clk(clk), .bt_reset(bt_reset), .inop(inop), .bt(bt), .in(sw),
        .du(du0), .await(aw0), .done(dn0), .count(cnt0)
    );

    io_input_responder #(.DEBOUNCE_CYCLES(4), .SIGN_EXT(1'b1)) u1 (
        .clk(clk), .bt_reset(bt_reset), .inop(inop), .bt(bt), .in(sw),
        .du(du1), .await(aw1), .done(dn1), .count(cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (dn0) ndone++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (dn0) seen = 1'b1;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    task automatic capture(input logic [13:0] v, input string tag);
        sw   = v;
        inop = 1'b1;
        bt   = 1'b1;
        wait_done(tag);
        inop = 1'b0;
        bt   = 1'b0;
        cyc(10);
    endtask

    initial begin
        // reset state; await follows inop even in reset
        cyc(2);
        check("rst_du", du0, 32'h0);
        check("rst_done", 32'(dn0), 32'd0);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_await", 32'(aw0), 32'd0);
        inop = 1'b1;
        #1;
        check("rst_await_follow", 32'(aw0), 32'd1);
        inop = 1'b0;
        cyc(1);
        bt_reset = 1'b1;
        cyc(3);

        // test 1: exact latency, zero extension
        sw   = 14'h2A5;
        inop = 1'b1;
        #1;
        check("t1_await_rise", 32'(aw0), 32'd1);
        cyc(2);
        check("t1_no_done", 32'(dn0), 32'd0);
        bt = 1'b1;
        cyc(6);
        check("t1_done_early", 32'(dn0), 32'd0);
        cyc(1);
        check("t1_done", 32'(dn0), 32'd1);
        check("t1_await_ack", 32'(aw0), 32'd0);
        check("t1_du", du0, 32'h000002A5);
        check("t1_du_sx", du1, 32'h000002A5);
        check("t1_count", 32'(cnt0), 32'd1);
        cyc(1);
        check("t1_done_once", 32'(dn0), 32'd0);
        check("t1_await_rel", 32'(aw0), 32'd1);
        inop = 1'b0;
        bt   = 1'b0;
        cyc(10);

        // test 2: sign extension
        capture(14'h3FFE, "t2a");
        check("t2a_du_sx", du1, 32'hFFFFFFFE);
        check("t2a_du_zx", du0, 32'h00003FFE);
        capture(14'h1FFE, "t2b");
        check("t2b_du_sx", du1, 32'h00001FFE);
        check("t2b_count", 32'(cnt0), 32'd3);

        // test 3: bouncing button
        n0   = ndone;
        inop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bt = 1'b1;
            cyc(2);
            bt = 1'b0;
            cyc(2);
        end
        check("t3_bounce", 32'(ndone - n0), 32'd0);
        bt = 1'b1;
        cyc(12);
        check("t3_one_done", 32'(ndone - n0), 32'd1);
        check("t3_count", 32'(cnt0), 32'd4);
        inop = 1'b0;
        bt   = 1'b0;
        cyc(10);

        // test 4: button already held
        bt = 1'b1;
        cyc(4);
        inop = 1'b1;
        n0   = ndone;
        cyc(12);
        check("t4_held", 32'(ndone - n0), 32'd0);
        check("t4_await", 32'(aw0), 32'd1);
        bt = 1'b0;
        cyc(8);
        check("t4_released", 32'(ndone - n0), 32'd0);
        bt = 1'b1;
        cyc(12);
        check("t4_one_done", 32'(ndone - n0), 32'd1);
        check("t4_count", 32'(cnt0), 32'd5);
        inop = 1'b0;
        bt   = 1'b0;
        cyc(10);

        // test 5: abort mid-debounce, then reset mid-wait
        dv   = du0;
        n0   = ndone;
        inop = 1'b1;
        bt   = 1'b1;
        cyc(4);
        inop = 1'b0;
        cyc(1);
        bt = 1'b0;
        cyc(10);
        check("t5_no_done", 32'(ndone - n0), 32'd0);
        check("t5_du_kept", du0, dv);
        check("t5_count", 32'(cnt0), 32'd5);
        check("t5_await", 32'(aw0), 32'd0);
        inop = 1'b1;
        cyc(3);
        bt_reset = 1'b0;
        #1;
        check("t5_rst_du", du0, 32'h0);
        check("t5_rst_count", 32'(cnt0), 32'd0);
        check("t5_rst_await", 32'(aw0), 32'd1);
        check("t5_rst_done", 32'(dn0), 32'd0);
        cyc(2);
        bt_reset = 1'b1;
        capture(14'h0123, "t5_restart");
        check("t5_restart_du", du0, 32'h00000123);
        check("t5_restart_count", 32'(cnt0), 32'd1);

        // test 6: 256 captures wrap count
        for (int i = 0; i < 256; i++) begin
            capture(14'(i), "t6");
            if (i == 254) check("t6_wrap0", 32'(cnt0), 32'd0);
        end
        check("t6_wrap1", 32'(cnt0), 32'd1);
        check("t6_du", du0, 32'h000000FF);

        // new request during WAIT_RELEASE
        sw   = 14'h0ABC;
        inop = 1'b1;
        bt   = 1'b1;
        wait_done("t6b_first");
        inop = 1'b0;
        cyc(1);
        inop = 1'b1;
        n0   = ndone;
        cyc(12);
        check("t6b_held", 32'(ndone - n0), 32'd0);
        check("t6b_await", 32'(aw0), 32'd1);
        bt = 1'b0;
        cyc(8);
        check("t6b_released", 32'(ndone - n0), 32'd0);
        bt = 1'b1;
        cyc(12);
        check("t6b_one_done", 32'(ndone - n0), 32'd1);
        check("t6b_count", 32'(cnt0), 32'd3);
        check("t6b_du", du0, 32'h00000ABC);
        inop = 1'b0;
        bt   = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
